// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: CPU port <-> cache array <-> word-wide memory bus (cs/we/ack).
// Latency: hits in 0 extra cycles; clean miss = 4 fill acks + 2; dirty miss adds 4 write-back acks.
// Backpressure: stall holds the CPU for a whole miss; memory ack gates every word. Optional stats: CACHE_CTRL_STAT_EN.
module cache_ctrl #(
   parameter int ADDR_BITS        = 32,
   parameter int WORD_BITS        = 32,
   parameter int TAG_BITS         = 22,
   parameter int WORD_BYTES_WIDTH = 2,
   parameter int LINE_WORDS_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_r,
   input  logic                 en_w,
   input  logic [ADDR_BITS-1:0] addr_rw,
   input  logic [WORD_BITS-1:0] data_w,
   output logic [WORD_BITS-1:0] data_r,
   output logic                 stall,
   output logic [ADDR_BITS-1:0] cache_addr,
   output logic                 cache_store,
   output logic                 cache_edit,
   output logic                 cache_invalid,
   output logic [WORD_BITS-1:0] cache_din,
   input  logic                 cache_hit,
   input  logic [WORD_BITS-1:0] cache_dout,
   input  logic                 cache_valid,
   input  logic                 cache_dirty,
   input  logic [TAG_BITS-1:0]  cache_tag,
   output logic                 mem_cs_o,
   output logic                 mem_we_o,
   output logic [ADDR_BITS-1:0] mem_addr_o,
   output logic [WORD_BITS-1:0] mem_data_o,
   input  logic [WORD_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
`ifdef CACHE_CTRL_STAT_EN
   ,
   output logic [31:0]          hit_cnt,
   output logic [31:0]          miss_cnt
`endif
);

   localparam int OFF_BITS  = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;
   localparam int LINE_BITS = ADDR_BITS - OFF_BITS;   // tag + index
   localparam int IDX_BITS  = LINE_BITS - TAG_BITS;
   localparam logic [LINE_WORDS_WIDTH-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BACK = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                      state, state_nx;
   logic [LINE_WORDS_WIDTH-1:0] cnt, cnt_nx;
   // Only the line part of the missing address is kept; word offset comes from cnt.
   logic [LINE_BITS-1:0]        req_addr, req_addr_nx;
   logic [TAG_BITS-1:0]         victim_tag, victim_tag_nx;
   logic                        req;

   logic [TAG_BITS-1:0]         req_tag;
   logic [IDX_BITS-1:0]         req_idx;

   assign req     = en_r | en_w;
   assign req_tag = req_addr[LINE_BITS-1 -: TAG_BITS];
   assign req_idx = req_addr[IDX_BITS-1:0];
   // Read data is a straight passthrough of the array; it is only meaningful when stall=0.
   assign data_r  = cache_dout;

   // State, word counter and latched miss context.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_addr   <= '0;
         victim_tag <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         req_addr   <= req_addr_nx;
         victim_tag <= victim_tag_nx;
      end
   end

   // Next-state and all array/memory strobes; everything defaults to idle values.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      req_addr_nx   = req_addr;
      victim_tag_nx = victim_tag;
      stall         = 1'b0;
      cache_addr    = addr_rw;
      cache_store   = 1'b0;
      cache_edit    = 1'b0;
      cache_invalid = 1'b0;   // reserved for a future flush path
      cache_din     = '0;
      mem_cs_o      = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;

      case (state)
         S_IDLE: begin
            if (req) begin
               if (cache_hit) begin
                  if (en_w) begin
                     cache_edit = 1'b1;
                     cache_din  = data_w;
                  end
               end else begin
                  stall         = 1'b1;
                  req_addr_nx   = addr_rw[ADDR_BITS-1:OFF_BITS];
                  victim_tag_nx = cache_tag;
                  cnt_nx        = '0;
                  state_nx      = (cache_valid && cache_dirty) ? S_BACK : S_FILL;
               end
            end
         end

         S_BACK: begin
            stall      = 1'b1;
            cache_addr = {victim_tag, req_idx, cnt, {WORD_BYTES_WIDTH{1'b0}}};
            mem_cs_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = cache_addr;
            mem_data_o = cache_dout;
            if (mem_ack_i) begin
               cnt_nx = cnt + CNT_ONE;
               if (&cnt) begin
                  state_nx = S_FILL;
               end
            end
         end

         S_FILL: begin
            stall      = 1'b1;
            cache_addr = {req_tag, req_idx, cnt, {WORD_BYTES_WIDTH{1'b0}}};
            mem_cs_o   = 1'b1;
            mem_addr_o = cache_addr;
            if (mem_ack_i) begin
               // Store wins over edit for the flags: line ends valid, clean, new tag.
               cache_store = 1'b1;
               cache_edit  = 1'b1;
               cache_din   = mem_data_i;
               cnt_nx      = cnt + CNT_ONE;
               if (&cnt) begin
                  state_nx = S_DONE;
               end
            end
         end

         S_DONE: begin
            // One quiet cycle, then the held request replays in S_IDLE and hits.
            stall      = 1'b1;
            cache_addr = {req_addr, {OFF_BITS{1'b0}}};
            state_nx   = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

`ifdef CACHE_CTRL_STAT_EN
   logic replay;

   // Hit/miss counters; the hit that replays a just-serviced miss is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         replay   <= 1'b0;
      end else begin
         replay <= (state == S_DONE);
         if (state == S_IDLE && req && cache_hit && !replay) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (state == S_IDLE && req && !cache_hit) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache array + memory with programmable ack delay.
// CPU requests come from a vector table; memory bus traffic is checked against a scoreboard queue.
// A few hand sequences cover reset mid-fill and the optional statistics counters.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_r, en_w;
   logic [31:0] addr_rw, data_w, data_r;
   logic        stall;
   logic [31:0] cache_addr;
   logic        cache_store, cache_edit, cache_invalid;
   logic [31:0] cache_din;
   logic        cache_hit;
   logic [31:0] cache_dout;
   logic        cache_valid, cache_dirty;
   logic [21:0] cache_tag;
   logic        mem_cs_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_ack_i;
`ifdef CACHE_CTRL_STAT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_rw(addr_rw),
      .data_w(data_w), .data_r(data_r), .stall(stall), .cache_addr(cache_addr),
      .cache_store(cache_store), .cache_edit(cache_edit), .cache_invalid(cache_invalid),
      .cache_din(cache_din), .cache_hit(cache_hit), .cache_dout(cache_dout),
      .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
      .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef CACHE_CTRL_STAT_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   // Background memory content: fixed lines for the test plan, address pattern elsewhere.
   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a[31:4] == 28'h0000010) return 32'hA0 + {30'd0, a[3:2]};
      if (a[31:4] == 28'h0040010) return 32'hB0 + {30'd0, a[3:2]};
      return a ^ 32'hC0DE0000;
   endfunction

   // ---------------- behavioural cache array (64 lines x 4 words) ----------------
   logic [31:0] c_data  [64][4] = '{default: '{default: 32'h0}};
   logic        c_valid [64]    = '{default: 1'b0};
   logic        c_dirty [64]    = '{default: 1'b0};
   logic [21:0] c_tagm  [64]    = '{default: 22'h0};
   logic [5:0]  c_idx;
   logic [1:0]  c_wd;
   assign c_idx       = cache_addr[9:4];
   assign c_wd        = cache_addr[3:2];
   assign cache_dout  = c_data[c_idx][c_wd];
   assign cache_valid = c_valid[c_idx];
   assign cache_dirty = c_dirty[c_idx];
   assign cache_tag   = c_tagm[c_idx];
   assign cache_hit   = c_valid[c_idx] && (c_tagm[c_idx] == cache_addr[31:10]);

   always @(posedge clk) begin
      if (cache_edit) c_data[c_idx][c_wd] <= cache_din;
      if (cache_store) begin
         c_valid[c_idx] <= 1'b1;
         c_dirty[c_idx] <= 1'b0;
         c_tagm[c_idx]  <= cache_addr[31:10];
      end else if (cache_edit) begin
         c_dirty[c_idx] <= 1'b1;
      end
      if (cache_invalid) c_valid[c_idx] <= 1'b0;
   end

   // ---------------- memory with ack after mem_delay wait cycles ----------------
   logic [31:0] mem_w  [1024] = '{default: 32'h0};
   logic        mem_wr [1024] = '{default: 1'b0};
   logic [9:0]  mi;
   int          mem_delay = 0;
   int          wcnt = 0;
   assign mi         = {mem_addr_o[22], mem_addr_o[10:2]};
   assign mem_ack_i  = mem_cs_o && (wcnt == mem_delay);
   assign mem_data_i = mem_wr[mi] ? mem_w[mi] : init_val(mem_addr_o);

   always @(posedge clk) begin
      if (mem_cs_o && mem_we_o && mem_ack_i) begin
         mem_w[mi]  <= mem_data_o;
         mem_wr[mi] <= 1'b1;
      end
      if (!mem_cs_o || mem_ack_i) wcnt <= 0;
      else                        wcnt <= wcnt + 1;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_txn_t;
   mem_txn_t exp_q[$];

   // Shadow of the coherent memory image, used to predict write-back data.
   logic [31:0] sh_w [1024] = '{default: 32'h0};
   logic        sh_v [1024] = '{default: 1'b0};
   function automatic logic [31:0] shadow_rd(input logic [31:0] a);
      logic [9:0] i;
      i = {a[22], a[10:2]};
      return sh_v[i] ? sh_w[i] : init_val(a);
   endfunction

   // Memory bus monitor: every acked word is popped from the scoreboard; waits must hold still.
   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        prev_we   = 1'b0;
   always @(negedge clk) begin
      mem_txn_t t;
      if (mem_cs_o && prev_wait) begin
         chk("mem_addr_hold", mem_addr_o, prev_addr);
         chk("mem_we_hold", {31'd0, mem_we_o}, {31'd0, prev_we});
      end
      if (mem_cs_o && mem_ack_i) begin
         chk("cache_invalid", {31'd0, cache_invalid}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("mem_unexpected_txn", mem_addr_o, 32'hFFFFFFFF);
         end else begin
            t = exp_q.pop_front();
            chk("mem_we", {31'd0, mem_we_o}, {31'd0, t.we});
            chk("mem_addr", mem_addr_o, t.addr);
            if (t.we) chk("mem_wdata", mem_data_o, t.data);
         end
      end
      prev_wait = mem_cs_o && !mem_ack_i;
      prev_addr = mem_addr_o;
      prev_we   = mem_we_o;
   end

   // One CPU request: hold until stall drops, check stall length and the accepted data.
   task automatic do_req(input bit is_w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input int exp_stall);
      int  stalls;
      bit  done;
      stalls = 0;
      done   = 1'b0;
      @(posedge clk); #1;
      en_r = !is_w; en_w = is_w; addr_rw = a; data_w = wd;
      while (!done) begin
         @(negedge clk);
         if (!stall) done = 1'b1;
         else begin
            stalls++;
            if (stalls > 400) begin
               chk("stall_timeout", 32'(stalls), 32'(exp_stall));
               done = 1'b1;
            end
         end
      end
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
      if (is_w) begin
         chk("wr_edit", {31'd0, cache_edit}, 32'd1);
         chk("wr_din", cache_din, wd);
      end else begin
         chk("rd_data", data_r, exp_d);
      end
      @(posedge clk); #1;
      en_r = 1'b0; en_w = 1'b0;
   endtask

   task automatic push_line(input bit we, input logic [31:0] base);
      mem_txn_t t;
      for (int i = 0; i < 4; i++) begin
         t.we   = we;
         t.addr = {base[31:4], 4'h0} + 32'(4 * i);
         t.data = we ? shadow_rd(t.addr) : 32'h0;
         exp_q.push_back(t);
      end
   endtask

   typedef struct {
      int          delay;
      bit          is_w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      bit          miss;
      bit          wb;
      logic [31:0] wb_base;
   } vec_t;
   vec_t vecs[10];

   initial begin
      int exp_stall;
      mem_txn_t t;
      vecs[0] = '{0, 1'b0, 32'h00000100, 32'h0,        32'h000000A0, 1'b1, 1'b0, 32'h0};
      vecs[1] = '{0, 1'b1, 32'h00000104, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
      vecs[2] = '{0, 1'b0, 32'h00000104, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{0, 1'b0, 32'h00400104, 32'h0,        32'h000000B1, 1'b1, 1'b1, 32'h00000100};
      vecs[4] = '{3, 1'b0, 32'h00000100, 32'h0,        32'h000000A0, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{0, 1'b0, 32'h00000104, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{0, 1'b0, 32'h0000010C, 32'h0,        32'h000000A3, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{0, 1'b1, 32'h00000200, 32'h12345678, 32'h0,        1'b1, 1'b0, 32'h0};
      vecs[8] = '{0, 1'b0, 32'h00000200, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0};
      vecs[9] = '{0, 1'b0, 32'h00000204, 32'h0,        32'hC0DE0204, 1'b0, 1'b0, 32'h0};

      // Reset state
      rst = 1'b1; en_r = 1'b0; en_w = 1'b0; addr_rw = 32'h00001234; data_w = 32'h0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mem_cs", {31'd0, mem_cs_o}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_store", {31'd0, cache_store}, 32'd0);
      chk("rst_edit", {31'd0, cache_edit}, 32'd0);
      chk("rst_invalid", {31'd0, cache_invalid}, 32'd0);
      chk("rst_cache_addr", cache_addr, 32'h00001234);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven CPU traffic
      for (int k = 0; k < 10; k++) begin
         mem_delay = vecs[k].delay;
         if (vecs[k].wb)   push_line(1'b1, vecs[k].wb_base);
         if (vecs[k].miss) push_line(1'b0, vecs[k].addr);
         exp_stall = !vecs[k].miss ? 0 : ((vecs[k].wb ? 8 : 4) * (vecs[k].delay + 1) + 2);
         do_req(vecs[k].is_w, vecs[k].addr, vecs[k].wdata, vecs[k].exp_data, exp_stall);
         if (vecs[k].is_w) begin
            sh_w[{vecs[k].addr[22], vecs[k].addr[10:2]}] = vecs[k].wdata;
            sh_v[{vecs[k].addr[22], vecs[k].addr[10:2]}] = 1'b1;
         end
         chk("sb_drained", 32'(exp_q.size()), 32'd0);
      end

      // Reset in S_FILL at cnt=2: three words land, then a fresh lookup hits the partial line
      mem_delay = 0;
      for (int i = 0; i < 3; i++) begin
         t.we = 1'b0; t.addr = 32'h300 + 32'(4 * i); t.data = 32'h0;
         exp_q.push_back(t);
      end
      @(posedge clk); #1;
      en_r = 1'b1; addr_rw = 32'h00000300;
      @(negedge clk);
      chk("rf_idle_miss_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("rf_fill0_addr", mem_addr_o, 32'h300);
      @(negedge clk);
      chk("rf_fill1_addr", mem_addr_o, 32'h304);
      @(negedge clk);
      chk("rf_fill2_addr", mem_addr_o, 32'h308);
      chk("rf_fill2_cs", {31'd0, mem_cs_o}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rf_after_rst_cs", {31'd0, mem_cs_o}, 32'd0);
      chk("rf_after_rst_stall", {31'd0, stall}, 32'd0);
      chk("rf_after_rst_data", data_r, 32'hC0DE0300);
      @(posedge clk); #1;
      en_r = 1'b0;
      chk("rf_sb_drained", 32'(exp_q.size()), 32'd0);

      // Fresh reset, one miss then three hits (statistics when enabled)
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      push_line(1'b0, 32'h00000500);
      do_req(1'b0, 32'h00000500, 32'h0, 32'hC0DE0500, 6);
      do_req(1'b0, 32'h00000504, 32'h0, 32'hC0DE0504, 0);
      do_req(1'b0, 32'h00000508, 32'h0, 32'hC0DE0508, 0);
      do_req(1'b0, 32'h00000500, 32'h0, 32'hC0DE0500, 0);
      chk("st_sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef CACHE_CTRL_STAT_EN
      chk("miss_cnt", miss_cnt, 32'd1);
      chk("hit_cnt", hit_cnt, 32'd3);
`endif

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
